// File: rtl/shift_word_buffer.sv
// shift_word_buffer: first-word-fall-through FIFO that sits behind the shift stage.
// The shift stage cannot be stalled, so a word arriving while the FIFO is full
// is dropped and remembered in a sticky overflow flag. Every accepted word is
// folded into a running XOR checksum for debug.
module shift_word_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3    // log2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic [AW:0]       count,
    output logic              full,
    input  logic              clr_ovf,
    output logic              overflow,
    output logic [WIDTH-1:0]  checksum
);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             ovf;
    logic [WIDTH-1:0] csum;

    logic push;
    logic pop;
    logic drop;

    // Outputs come only from registered state; nothing flows from in_* to out_*.
    always_comb begin
        out_valid = (cnt != '0);
        full      = (cnt == DEPTH_C);
        out_data  = out_valid ? mem[rd_ptr] : '0;
        count     = cnt;
        overflow  = ovf;
        checksum  = csum;
        pop       = out_valid & out_ready;
        // A pop frees the head slot this edge, so a full FIFO can still take a word.
        push      = in_valid & (~full | pop);
        drop      = in_valid & full & ~pop;
    end

    // Storage write; when full-with-pop, wr_ptr equals rd_ptr and the head is
    // overwritten at the same edge it is consumed, which is safe.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers, occupancy, sticky overflow (set wins over clear) and checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            csum   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                csum   <= csum ^ in_data;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                cnt <= cnt + CNT_ONE;
            end else if (pop && !push) begin
                cnt <= cnt - CNT_ONE;
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_word_buffer.sv
// Directed bench for shift_word_buffer. Inputs change 1ns after the rising
// edge and outputs are sampled at that same point, well away from the edge.
module tb_shift_word_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [AW:0]      count;
    logic             full;
    logic             clr_ovf = 1'b0;
    logic             overflow;
    logic [WIDTH-1:0] checksum;

    int total = 0;
    int bad   = 0;

    shift_word_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .count(count), .full(full), .clr_ovf(clr_ovf), .overflow(overflow),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, land 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Push words 1..n with out_ready low.
    task automatic fill(input int n);
        for (int i = 1; i <= n; i++) begin
            in_valid = 1'b1; in_data = WIDTH'(i); out_ready = 1'b0;
            step();
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        total++; if (count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        total++; if (checksum !== '0) begin bad++; $display("FAIL reset_checksum got=%h exp=0", checksum); end
        // out_ready while empty must not underflow
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++; if (count !== '0) begin bad++; $display("FAIL empty_pop_count got=%0d exp=0", count); end
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 1'b1; in_data = 32'hA5A5_0001;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL no_bypass got=%b exp=0", out_valid); end
        step();
        idle_inputs();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 32'hA5A5_0001) begin bad++; $display("FAIL single_data got=%h exp=a5a50001", out_data); end
        total++; if (count !== 4'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
        total++; if (checksum !== 32'hA5A5_0001) begin bad++; $display("FAIL single_checksum got=%h exp=a5a50001", checksum); end
    endtask

    task automatic test_overflow();
        do_reset();
        fill(8);
        total++; if (full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b exp=1", full); end
        total++; if (count !== 4'd8) begin bad++; $display("FAIL ovf_count8 got=%0d exp=8", count); end
        in_valid = 1'b1; in_data = 32'h9;
        step();
        idle_inputs();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        total++; if (count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", count); end
        total++; if (checksum !== 32'h8) begin bad++; $display("FAIL ovf_checksum got=%h exp=8", checksum); end
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            total++; if (out_data !== WIDTH'(i)) begin bad++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, out_data, i); end
            step();
        end
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained_valid got=%b exp=0", out_valid); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_full_pop();
        do_reset();
        fill(8);
        in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b1;
        step();
        idle_inputs();
        total++; if (count !== 4'd8) begin bad++; $display("FAIL fullpop_count got=%0d exp=8", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fullpop_overflow got=%b exp=0", overflow); end
        total++; if (checksum !== 32'h5D) begin bad++; $display("FAIL fullpop_checksum got=%h exp=5d", checksum); end
        out_ready = 1'b1;
        for (int i = 2; i <= 9; i++) begin
            logic [WIDTH-1:0] exp_w;
            exp_w = (i == 9) ? 32'h55 : WIDTH'(i);
            total++; if (out_data !== exp_w) begin bad++; $display("FAIL fullpop_drain[%0d] got=%h exp=%h", i, out_data, exp_w); end
            step();
        end
        out_ready = 1'b0;
        total++; if (count !== '0) begin bad++; $display("FAIL fullpop_empty got=%0d exp=0", count); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = 32'h100 + 32'(i); out_ready = 1'b1;
            step();
            total++; if (count !== 4'd1) begin bad++; $display("FAIL stream_count[%0d] got=%0d exp=1", i, count); end
            total++; if (out_data !== 32'h100 + 32'(i)) begin bad++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, out_data, 32'h100 + 32'(i)); end
        end
        idle_inputs();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL stream_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] q[$];
        logic [WIDTH-1:0] next_w;
        logic             do_pop;
        do_reset();
        next_w = 32'hC000;
        for (int c = 0; c < 30; c++) begin
            idle_inputs();
            if ((c % 5) < 3) begin
                in_valid = 1'b1; in_data = next_w;
            end else begin
                out_ready = 1'b1;
            end
            do_pop = out_ready && (q.size() > 0);
            if (do_pop) begin
                total++; if (out_data !== q[0]) begin bad++; $display("FAIL wrap_data[%0d] got=%h exp=%h", c, out_data, q[0]); end
                void'(q.pop_front());
            end
            if (in_valid && q.size() < DEPTH) begin
                q.push_back(next_w);
                next_w = next_w + 32'h1;
            end
            step();
            total++; if (count !== (AW+1)'(q.size())) begin bad++; $display("FAIL wrap_count[%0d] got=%0d exp=%0d", c, count, q.size()); end
        end
        idle_inputs();
        out_ready = 1'b1;
        while (q.size() > 0) begin
            total++; if (out_data !== q[0]) begin bad++; $display("FAIL wrap_tail got=%h exp=%h", out_data, q[0]); end
            void'(q.pop_front());
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        fill(8);
        in_valid = 1'b1; in_data = 32'hDEAD;
        step();
        idle_inputs();
        out_ready = 1'b1;
        step(); step(); step();
        out_ready = 1'b0;
        total++; if (count !== 4'd5 || overflow !== 1'b1) begin bad++; $display("FAIL mid_setup got=%0d/%b exp=5/1", count, overflow); end
        rst = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF; out_ready = 1'b1;
        step();
        rst = 1'b0;
        idle_inputs();
        total++; if ({out_valid, out_data, count, full, overflow, checksum} !== '0) begin
            bad++; $display("FAIL mid_reset got=v%b d%h c%0d f%b o%b s%h exp=all0", out_valid, out_data, count, full, overflow, checksum);
        end
        fill(8);
        in_valid = 1'b1; in_data = 32'h77; clr_ovf = 1'b1;
        step();
        idle_inputs();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL set_wins got=%b exp=1", overflow); end
        total++; if (checksum !== 32'h8) begin bad++; $display("FAIL drop_checksum got=%h exp=8", checksum); end
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_overflow();
        test_full_pop();
        test_stream();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
